// File: rtl/hw_regs_dbuf.sv
// hw_regs_dbuf: GFX hardware control register bank.
// Holds a staging (stg) and an active (act) copy of the register file. Active bytes
// drive the HW_REGS views. Bytes inside [DBUF_LO, DBUF_HI] reach act only on a commit.
// RESET_VALUES packs entry 1 in bits [23:0], entry 2 in [47:24], ...; each entry is
// {16-bit offset, 8-bit value}.
module hw_regs_dbuf #(
    parameter ENDIAN = "Big",
    parameter int PORT_ADDR_SIZE = 19,
    parameter int PORT_CACHE_BITS = 128,
    parameter int HW_REGS_SIZE = 12,
    parameter logic [31:0] BASE_WRITE_ADDRESS = 32'h0,
    parameter logic [15:0] DBUF_LO = 16'h0040,
    parameter logic [15:0] DBUF_HI = 16'h007F,
    parameter int RST_PARAM_SIZE = 4,
    parameter logic [((RST_PARAM_SIZE > 0) ? RST_PARAM_SIZE : 1)*24-1:0] RESET_VALUES = '0
) (
    input  logic                       CLK,
    input  logic                       RESET_N,
    input  logic                       WE,
    input  logic [PORT_ADDR_SIZE-1:0]  ADDR_IN,
    input  logic [PORT_CACHE_BITS-1:0] DATA_IN,
    input  logic [PORT_CACHE_BITS/8-1:0] WMASK,
    input  logic                       RE,
    input  logic [PORT_ADDR_SIZE-1:0]  RD_ADDR,
    output logic [PORT_CACHE_BITS-1:0] RD_DATA,
    output logic                       RD_VALID,
    input  logic                       UPDATE,
    output logic                       DIRTY,
    output logic                       COMMITTED,
    output logic [7:0]                 HW_REGS__8bit [0:2**HW_REGS_SIZE-1],
    output logic [15:0]                HW_REGS_16bit [0:2**HW_REGS_SIZE-1],
    output logic [31:0]                HW_REGS_32bit [0:2**HW_REGS_SIZE-1]
);

    localparam int          BYTES    = PORT_CACHE_BITS / 8;
    localparam int          LB       = $clog2(BYTES);
    localparam int          HRS      = HW_REGS_SIZE;
    localparam int unsigned N        = 2 ** HW_REGS_SIZE;
    localparam int unsigned LANE_MAX = BYTES - 1;
    localparam bit          BIG      = (ENDIAN[$bits(ENDIAN)-1 -: 8] == 8'h42);

    typedef enum logic {ST_CLEAN, ST_DIRTY} state_t;

    logic [7:0]     stg  [0:N-1];
    logic [7:0]     act  [0:N-1];
    logic [7:0]     actx [0:N+2];
    logic           wr_hit, rd_hit, buf_wr, commit, committed_q;
    logic [HRS-1:0] wr_line, rd_line;
    state_t         state_q, state_d;
    logic           unused_addr_lsbs;

    function automatic logic [HRS-1:0] lane_addr(input logic [HRS-1:0] line, input int unsigned lane);
        return line | HRS'(lane ^ LANE_MAX);
    endfunction

    function automatic logic in_dbuf(input logic [HRS-1:0] b);
        return (32'(b) >= 32'(DBUF_LO)) && (32'(b) <= 32'(DBUF_HI));
    endfunction

    // Base is aligned to the file size, so comparing the upper bits is the full range check.
    assign wr_hit  = (ADDR_IN[PORT_ADDR_SIZE-1:HRS] == BASE_WRITE_ADDRESS[PORT_ADDR_SIZE-1:HRS]);
    assign rd_hit  = (RD_ADDR[PORT_ADDR_SIZE-1:HRS] == BASE_WRITE_ADDRESS[PORT_ADDR_SIZE-1:HRS]);
    assign wr_line = {ADDR_IN[HRS-1:LB], {LB{1'b0}}};
    assign rd_line = {RD_ADDR[HRS-1:LB], {LB{1'b0}}};
    assign unused_addr_lsbs = ^{ADDR_IN[LB-1:0], RD_ADDR[LB-1:0]};

    // Detect any enabled write byte that falls in the double-buffered window.
    always_comb begin
        buf_wr = 1'b0;
        for (int unsigned i = 0; i < BYTES; i++) begin
            if (WE && wr_hit && WMASK[i] && in_dbuf(lane_addr(wr_line, i)))
                buf_wr = 1'b1;
        end
    end

    // Staging/active storage: reset load, commit copy, then line writes.
    // Commit reads pre-edge stg, so a concurrent buffered write waits for the next commit.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int unsigned j = 0; j < N; j++) begin
                stg[j] <= '0;
                act[j] <= '0;
            end
            for (int unsigned k = 0; k < RST_PARAM_SIZE; k++) begin
                if (32'(RESET_VALUES[k*24+8 +: 16]) < N) begin
                    stg[RESET_VALUES[k*24+8 +: HRS]] <= RESET_VALUES[k*24 +: 8];
                    act[RESET_VALUES[k*24+8 +: HRS]] <= RESET_VALUES[k*24 +: 8];
                end
            end
        end else begin
            if (commit) begin
                for (int unsigned j = 0; j < N; j++) begin
                    if (in_dbuf(HRS'(j)))
                        act[j] <= stg[j];
                end
            end
            if (WE && wr_hit) begin
                for (int unsigned i = 0; i < BYTES; i++) begin
                    if (WMASK[i]) begin
                        stg[lane_addr(wr_line, i)] <= DATA_IN[i*8 +: 8];
                        if (!in_dbuf(lane_addr(wr_line, i)))
                            act[lane_addr(wr_line, i)] <= DATA_IN[i*8 +: 8];
                    end
                end
            end
        end
    end

    // Registered line readback from staging; misses return zero.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            RD_VALID <= 1'b0;
            RD_DATA  <= '0;
        end else begin
            RD_VALID <= RE;
            if (RE) begin
                for (int unsigned i = 0; i < BYTES; i++)
                    RD_DATA[i*8 +: 8] <= rd_hit ? stg[lane_addr(rd_line, i)] : 8'h00;
            end
        end
    end

    // Commit state register and pulse.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= ST_CLEAN;
            committed_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            committed_q <= commit;
        end
    end

    // Next-state: commit on UPDATE while dirty; a same-edge buffered write keeps it dirty.
    always_comb begin
        state_d = state_q;
        commit  = 1'b0;
        case (state_q)
            ST_CLEAN: if (buf_wr) state_d = ST_DIRTY;
            ST_DIRTY: begin
                if (UPDATE) begin
                    commit  = 1'b1;
                    state_d = buf_wr ? ST_DIRTY : ST_CLEAN;
                end
            end
            default: state_d = ST_CLEAN;
        endcase
    end

    assign DIRTY     = (state_q == ST_DIRTY);
    assign COMMITTED = committed_q;

    // Active bytes, zero-extended past the top for the wide views.
    always_comb begin
        for (int unsigned k = 0; k < N; k++) begin
            actx[k]          = act[k];
            HW_REGS__8bit[k] = act[k];
        end
        for (int unsigned k = N; k < N + 3; k++)
            actx[k] = '0;
    end

    // 16/32-bit views composed in the configured byte order.
    always_comb begin
        for (int unsigned x = 0; x < N; x++) begin
            if (BIG) begin
                HW_REGS_16bit[x] = {actx[x], actx[x+1]};
                HW_REGS_32bit[x] = {actx[x], actx[x+1], actx[x+2], actx[x+3]};
            end else begin
                HW_REGS_16bit[x] = {actx[x+1], actx[x]};
                HW_REGS_32bit[x] = {actx[x+3], actx[x+2], actx[x+1], actx[x]};
            end
        end
    end

endmodule

// File: tb/tb_hw_regs_dbuf.sv
// tb_hw_regs_dbuf: scoreboard bench for hw_regs_dbuf (128-bit lines, 256-byte file at 0x1000).
module tb_hw_regs_dbuf;

    logic         CLK = 1'b0;
    logic         RESET_N;
    logic         WE, RE, UPDATE;
    logic [18:0]  ADDR_IN, RD_ADDR;
    logic [127:0] DATA_IN;
    logic [15:0]  WMASK;
    logic [127:0] RD_DATA;
    logic         RD_VALID, DIRTY, COMMITTED;
    logic [7:0]   r8  [0:255];
    logic [15:0]  r16 [0:255];
    logic [31:0]  r32 [0:255];

    int n_total = 0;
    int n_bad   = 0;

    bit [7:0]     m_stg [0:255];
    bit [7:0]     m_act [0:255];
    bit           m_dirty, exp_rv, exp_com;
    logic [127:0] rq [$];

    hw_regs_dbuf #(
        .ENDIAN("Big"), .PORT_ADDR_SIZE(19), .PORT_CACHE_BITS(128), .HW_REGS_SIZE(8),
        .BASE_WRITE_ADDRESS(32'h1000), .DBUF_LO(16'h0040), .DBUF_HI(16'h007F),
        .RST_PARAM_SIZE(1), .RESET_VALUES(24'h0010A5)
    ) dut (
        .CLK(CLK), .RESET_N(RESET_N), .WE(WE), .ADDR_IN(ADDR_IN), .DATA_IN(DATA_IN),
        .WMASK(WMASK), .RE(RE), .RD_ADDR(RD_ADDR), .RD_DATA(RD_DATA), .RD_VALID(RD_VALID),
        .UPDATE(UPDATE), .DIRTY(DIRTY), .COMMITTED(COMMITTED),
        .HW_REGS__8bit(r8), .HW_REGS_16bit(r16), .HW_REGS_32bit(r32)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit m_hit(input logic [18:0] a);
        return (a >= 19'h1000) && (a < 19'h1100);
    endfunction

    function automatic int m_off(input logic [18:0] a);
        return (int'(a) - 'h1000) & 'hF0;
    endfunction

    function automatic bit m_buf(input int b);
        return (b >= 'h40) && (b <= 'h7F);
    endfunction

    function automatic bit [7:0] m_at(input int x);
        return (x < 256) ? m_act[x] : 8'h00;
    endfunction

    task automatic model_reset();
        for (int j = 0; j < 256; j++) begin
            m_stg[j] = 8'h00;
            m_act[j] = 8'h00;
        end
        m_stg['h10] = 8'hA5;
        m_act['h10] = 8'hA5;
        m_dirty = 0;
        rq.delete();
    endtask

    task automatic idle_inputs();
        WE = 0; RE = 0; UPDATE = 0;
        ADDR_IN = '0; RD_ADDR = '0; DATA_IN = '0; WMASK = '0;
    endtask

    // Update the model with the inputs seen at the coming edge, then compare just after it.
    task automatic step();
        logic [127:0] line;
        bit bw, com;
        int b;
        exp_rv = RE;
        if (RE) begin
            line = '0;
            if (m_hit(RD_ADDR))
                for (int i = 0; i < 16; i++) line[i*8 +: 8] = m_stg[m_off(RD_ADDR) + 15 - i];
            rq.push_back(line);
        end
        bw = 0;
        if (WE && m_hit(ADDR_IN))
            for (int i = 0; i < 16; i++)
                if (WMASK[i] && m_buf(m_off(ADDR_IN) + 15 - i)) bw = 1;
        com = m_dirty && UPDATE;
        if (com)
            for (int j = 'h40; j <= 'h7F; j++) m_act[j] = m_stg[j];
        if (WE && m_hit(ADDR_IN))
            for (int i = 0; i < 16; i++)
                if (WMASK[i]) begin
                    b = m_off(ADDR_IN) + 15 - i;
                    m_stg[b] = DATA_IN[i*8 +: 8];
                    if (!m_buf(b)) m_act[b] = DATA_IN[i*8 +: 8];
                end
        m_dirty = com ? bw : (m_dirty | bw);
        exp_com = com;
        @(posedge CLK);
        #1;
        check("dirty", DIRTY, m_dirty);
        check("committed", COMMITTED, exp_com);
        check("rd_valid", RD_VALID, exp_rv);
        if (rq.size() != 0) check("rd_data", RD_DATA, rq.pop_front());
    endtask

    task automatic check_act();
        for (int j = 0; j < 256; j++) check($sformatf("act8[%0h]", j), r8[j], m_act[j]);
    endtask

    task automatic check_views(input int x);
        check($sformatf("v16[%0h]", x), r16[x], {m_at(x), m_at(x+1)});
        check($sformatf("v32[%0h]", x), r32[x], {m_at(x), m_at(x+1), m_at(x+2), m_at(x+3)});
    endtask

    initial begin
        idle_inputs();
        RESET_N = 0;
        model_reset();
        #12;
        check("rst_dirty", DIRTY, 0);
        check("rst_committed", COMMITTED, 0);
        check("rst_rd_valid", RD_VALID, 0);
        check("rst_rd_data", RD_DATA, 0);
        check("rst_act10", r8['h10], 8'hA5);
        check("rst_v16_10", r16['h10], 16'hA500);
        RESET_N = 1;
        #1;

        // Read the reset value back.
        RE = 1; RD_ADDR = 19'h1010;
        step();
        idle_inputs();
        check("t1_lane15", RD_DATA[127:120], 8'hA5);
        check("t1_others", RD_DATA[119:0], 0);

        // Unbuffered write goes straight to active.
        WE = 1; ADDR_IN = 19'h1000; DATA_IN = {8'h12, 8'h34, 112'h0}; WMASK = 16'hC000;
        step();
        idle_inputs();
        check("t2_act0", r8[0], 8'h12);
        check("t2_act1", r8[1], 8'h34);
        check("t2_v16_0", r16[0], 16'h1234);
        check("t2_v32_0", r32[0], 32'h1234_0000);

        // Buffered write, readback from staging, then commit.
        WE = 1; ADDR_IN = 19'h1040; DATA_IN = {8'hBE, 120'h0}; WMASK = 16'h8000;
        step();
        idle_inputs();
        check("t3_act40_pre", r8['h40], 8'h00);
        RE = 1; RD_ADDR = 19'h1040;
        step();
        idle_inputs();
        check("t3_stg40", RD_DATA[127:120], 8'hBE);
        UPDATE = 1;
        step();
        idle_inputs();
        check("t3_act40_post", r8['h40], 8'hBE);
        step();
        check("t3_pulse_once", COMMITTED, 0);

        // UPDATE while clean: nothing.
        UPDATE = 1;
        step();
        idle_inputs();

        // Buffered write on the commit edge waits for the next commit.
        WE = 1; ADDR_IN = 19'h1040; DATA_IN = {8'h11, 120'h0}; WMASK = 16'h8000;
        step();
        WE = 1; ADDR_IN = 19'h1050; DATA_IN = {8'h77, 120'h0}; WMASK = 16'h8000; UPDATE = 1;
        step();
        idle_inputs();
        check("t4_act40", r8['h40], 8'h11);
        check("t4_act50_pre", r8['h50], 8'h00);
        UPDATE = 1;
        step();
        idle_inputs();
        check("t4_act50_post", r8['h50], 8'h77);

        // Out-of-window writes and reads.
        WE = 1; ADDR_IN = 19'h0FF0; DATA_IN = {4{32'hDEADBEEF}}; WMASK = 16'hFFFF;
        step();
        ADDR_IN = 19'h1100;
        step();
        idle_inputs();
        check_act();
        RE = 1; RD_ADDR = 19'h1100;
        step();
        RD_ADDR = 19'h0FF0;
        step();
        idle_inputs();
        check("t5_miss_zero", RD_DATA, 0);

        // Random traffic against the model, including the top-of-file views.
        for (int n = 0; n < 300; n++) begin
            WE      = ($urandom_range(0, 1) == 1);
            ADDR_IN = 19'(($urandom_range('h0FE, 'h112)) << 4) | 19'($urandom_range(0, 15));
            DATA_IN = {$urandom, $urandom, $urandom, $urandom};
            WMASK   = 16'($urandom);
            RE      = ($urandom_range(0, 1) == 1);
            RD_ADDR = 19'(($urandom_range('h0FE, 'h112)) << 4);
            UPDATE  = ($urandom_range(0, 3) == 0);
            step();
            check_views(int'($urandom_range(0, 255)));
            if (n % 20 == 0) begin
                check_act();
                check_views(253);
                check_views(254);
                check_views(255);
            end
        end
        idle_inputs();
        step();
        check_act();

        // Asynchronous reset during a commit pulse and an outstanding read.
        WE = 1; ADDR_IN = 19'h1040; DATA_IN = {8'h5A, 120'h0}; WMASK = 16'h8000;
        step();
        WE = 1; ADDR_IN = 19'h1060; DATA_IN = {8'h3C, 120'h0}; UPDATE = 1; RE = 1; RD_ADDR = 19'h1040;
        step();
        idle_inputs();
        check("t6_dirty_pre", DIRTY, 1);
        #2;
        RESET_N = 0;
        #1;
        model_reset();
        check("t6_dirty", DIRTY, 0);
        check("t6_committed", COMMITTED, 0);
        check("t6_rd_valid", RD_VALID, 0);
        check("t6_rd_data", RD_DATA, 0);
        check("t6_act40", r8['h40], 8'h00);
        check("t6_act10", r8['h10], 8'hA5);
        RESET_N = 1;
        step();
        check_act();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
